// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB-first over WIDTH clocks.
// Optional subtract mode (input sub) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] psum;
   logic [WIDTH-1:0] psum_nx;
   logic             c;
   logic [CW-1:0]    cnt;

   logic             s;
   logic             c_nx;
   logic             last;
   logic [WIDTH-1:0] b_in;
   logic             c_in;

   always_comb begin
      s    = a_sh[0] ^ b_sh[0] ^ c;
      c_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
      // shift-then-insert keeps this legal for WIDTH == 1
      psum_nx            = psum >> 1;
      psum_nx[WIDTH-1]   = s;
      last               = (cnt == CW'(WIDTH - 1));
`ifdef SERIAL_ADDER_SUB_EN
      b_in = sub ? ~b : b;
      c_in = sub ? 1'b1 : cin;
`else
      b_in = b;
      c_in = cin;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         psum  <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b_in;
                  c     <= c_in;
                  psum  <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               c    <= c_nx;
               psum <= psum_nx;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  sum   <= psum_nx;
                  carry <= c_nx;
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 instance plus a WIDTH=1 instance.
// Subtract-mode stimulus is included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         busy, done, carry;
   logic [W-1:0] sum;

   logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
   logic busy1, done1, carry1;
   logic [0:0] sum1;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .busy(busy), .done(done), .sum(sum), .carry(carry)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
   );

   typedef struct { logic [W-1:0] s; logic c; int acc; } exp_t;
   typedef struct { logic s; logic c; int acc; } exp1_t;

   exp_t  q[$];
   exp1_t q1[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_acc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: unsigned add, or difference with carry = (x >= y)
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb, input int acc);
      exp_t e;
      longint unsigned t;
      if (sb) begin
         e.s = x - y;
         e.c = (x >= y);
      end else begin
         t   = longint'(x) + longint'(y) + longint'(ci);
         e.s = W'(t);
         e.c = t[W];
      end
      e.acc = acc;
      return e;
   endfunction

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Acceptance predictor: inputs change only just after posedge, so the
   // negedge view equals what the DUT samples at the next edge.
   always @(negedge clk) begin
      exp1_t e1;
      if (!rst_n) begin
         q.delete();
         q1.delete();
      end else begin
         if (start && !busy) begin
            q.push_back(model(a, b, cin, sub, cyc + 1));
            n_acc++;
         end
         if (start1 && !busy1) begin
            e1.s   = a1 ^ b1 ^ cin1;
            e1.c   = (int'(a1) + int'(b1) + int'(cin1)) >= 2;
            e1.acc = cyc + 1;
            q1.push_back(e1);
         end
      end
   end

   logic [W-1:0] hold_s = '0;
   logic         hold_c = 1'b0;
   logic         prev_done = 1'b0, prev_acc = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_sum", sum, 0);
         chk("rst_carry", carry, 0);
         hold_s = '0;
         hold_c = 1'b0;
         prev_done = 1'b0;
         prev_acc  = 1'b0;
      end else begin
         if (prev_acc) chk("busy_after_accept", busy, 1);
         if (prev_done) begin
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
         end
         if (done) begin
            if (q.size() == 0) flag("spurious_done");
            else begin
               e = q.pop_front();
               chk("sum", sum, e.s);
               chk("carry", carry, e.c);
               chk("latency", longint'(cyc - e.acc), W);
               hold_s = e.s;
               hold_c = e.c;
            end
         end else begin
            chk("sum_hold", sum, hold_s);
            chk("carry_hold", carry, hold_c);
         end
         prev_acc  = start && !busy;
         prev_done = done;
      end
   end

   always @(negedge clk) begin
      exp1_t e1;
      if (rst_n && done1) begin
         if (q1.size() == 0) flag("w1_spurious_done");
         else begin
            e1 = q1.pop_front();
            chk("w1_sum", sum1, e1.s);
            chk("w1_carry", carry1, e1.c);
            chk("w1_latency", longint'(cyc - e1.acc), 1);
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (busy) flag("timeout_wait_idle");
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
      wait_idle();
      a = x; b = y; cin = ci; sub = sb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'b0;
   endtask

   task automatic send1(input logic x, input logic y, input logic ci);
      int k = 0;
      while (busy1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (busy1) flag("w1_timeout_wait_idle");
      a1 = x; b1 = y; cin1 = ci; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      a1 = ~x; b1 = ~y; cin1 = ~ci;
   endtask

   initial begin
      int k;
      int target;
      logic sb;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      send(8'h00, 8'h00, 1'b0, 1'b0);
      send(8'hFF, 8'h01, 1'b0, 1'b0);
      send(8'hFF, 8'hFF, 1'b1, 1'b0);

      // start held high while busy: only the post-IDLE request is taken
      wait_idle();
      target = n_acc + 2;
      a = 8'h5A; b = 8'h33; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      a = 8'h11; b = 8'h22; cin = 1'b0;
      k = 0;
      while (n_acc < target && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (n_acc < target) flag("timeout_second_accept");
      start = 1'b0;

      // reset on the third RUN cycle aborts without a done pulse
      send(8'hAA, 8'h55, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_sum", sum, 0);
      chk("async_rst_carry", carry, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send(8'h01, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
      send(8'h10, 8'h01, 1'b0, 1'b1);
      send(8'h01, 8'h02, 1'b1, 1'b1);
      send(8'hFF, 8'h01, 1'b0, 1'b0);
      send(8'hFF, 8'hFF, 1'b1, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         sb = 1'($urandom);
`endif
         send(W'($urandom), W'($urandom), 1'($urandom), sb);
      end

      for (int i = 0; i < 8; i++) begin
         send1(i[2], i[1], i[0]);
      end

      k = 0;
      while ((q.size() != 0 || q1.size() != 0 || busy || busy1) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("queue_drained", q.size(), 0);
      chk("w1_queue_drained", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
